// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_arb_pkg                                                               |
// | Shared types, defaults and the winner search for mem_req_arbiter.         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int NUM_REQ_DEF   = 3;
  localparam int ADDR_W_DEF    = 20;
  localparam int DATA_W_DEF    = 16;
  localparam int TAG_DEPTH_DEF = 4;
  localparam int ID_W          = $clog2(NUM_REQ_DEF);

  // Upper bound on requesters the winner search can scan.
  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First set bit of req scanning upward from start, wrapping at n.
  function automatic int unsigned pick_winner(input logic [MAX_REQ-1:0] req,
                                              input int unsigned        start,
                                              input int unsigned        n);
    int unsigned idx;
    logic        found;
    pick_winner = 0;
    found       = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && req[idx[MAX_IDX_W-1:0]]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_tag_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_arb_tag_fifo                                                          |
// | Owner-id FIFO for accepted-but-unanswered memory requests.                |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mem_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_q];

  // A full FIFO may still take a push when the same cycle pops.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_req_arbiter                                                           |
// | Shares one memory request port among NUM_REQ fill engines and routes      |
// | responses back in order. MEM_ARB_ROUND_ROBIN_EN selects round-robin.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        ready_o,
  output logic [DATA_W-1:0]         from_mem_o,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic                      mem_req_ack_i,
  input  logic                      mem_ready_i,
  input  logic [DATA_W-1:0]         mem_data_i,
  output logic                      err_orphan_o
);

  localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t           state_q, state_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  logic             err_q, err_d;
  logic [GNT_W-1:0] tag_head, winner;
  logic             tag_full, tag_empty;
  logic             accept, pop, any_req, own_req;
  int unsigned      arb_start;

  assign any_req = |req_i;
  assign own_req = req_i[grant_q];

  assign mem_req_o  = (state_q == ST_GRANT) & own_req & ~tag_full;
  assign mem_addr_o = (state_q == ST_GRANT) ? req_addr_i[grant_q*ADDR_W +: ADDR_W] : '0;
  assign from_mem_o = mem_data_i;

  assign accept = mem_req_o & mem_req_ack_i;
  assign pop    = mem_ready_i & ~tag_empty;
  assign err_d  = err_q | (mem_ready_i & tag_empty);
  assign err_orphan_o = err_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [GNT_W-1:0] last_q, last_d, base;

  // The owner accepted this cycle already counts as the last owner for re-arbitration.
  assign last_d    = accept ? grant_q : last_q;
  assign base      = last_d;
  assign arb_start = (int'(base) == NUM_REQ - 1) ? 0 : int'(base) + 1;

  always_ff @(posedge clk) begin
    if (rst) last_q <= GNT_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end
`else
  assign arb_start = 0;
`endif

  assign winner = GNT_W'(pick_winner(MAX_REQ'(req_i), arb_start, NUM_REQ));

  always_comb begin
    req_ack_o = '0;
    ready_o   = '0;
    if (accept) req_ack_o[grant_q] = 1'b1;
    if (pop)    ready_o[tag_head]  = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          grant_d = winner;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          if (any_req) grant_d = winner;
          else         state_d = ST_IDLE;
        end else if (!own_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  mem_arb_tag_fifo #(
    .WIDTH (GNT_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (grant_q),
    .pop_i       (pop),
    .head_o      (tag_head),
    .empty_o     (tag_empty),
    .full_o      (tag_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_req_arbiter                                                        |
// | Self-checking bench: vector table, corner sequences, random vs. model.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_mem_req_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int TAG_DEPTH = 4;
  localparam int AW_ALL    = NUM_REQ * ADDR_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [AW_ALL-1:0]    req_addr;
  logic [NUM_REQ-1:0]   req_ack, ready;
  logic [DATA_W-1:0]    from_mem, mem_data;
  logic                 mem_req, mem_req_ack, mem_ready, err_orphan;
  logic [ADDR_W-1:0]    mem_addr;

  int tests_run    = 0;
  int tests_failed = 0;
  bit rand_addr    = 1'b0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .req_addr_i(req_addr),
    .req_ack_o(req_ack), .ready_o(ready), .from_mem_o(from_mem),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_req_ack_i(mem_req_ack),
    .mem_ready_i(mem_ready), .mem_data_i(mem_data), .err_orphan_o(err_orphan)
  );

  // Reference model: current owner (-1 = none), queue of outstanding owners.
  int m_owner, m_last;
  bit m_orphan;
  int m_tags[$];

  function automatic int pick(input logic [NUM_REQ-1:0] r);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      idx = (m_last + k) % NUM_REQ;
`else
      idx = k - 1;
`endif
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_last   = NUM_REQ - 1;
    m_orphan = 1'b0;
    m_tags.delete();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp_update();
    logic              e_mreq, acc;
    logic [ADDR_W-1:0] e_addr;
    logic [NUM_REQ-1:0] e_ack, e_rdy;
    int o;
    o      = (m_owner < 0) ? 0 : m_owner;
    e_mreq = (m_owner >= 0) && req[o] && (m_tags.size() < TAG_DEPTH);
    e_addr = (m_owner >= 0) ? req_addr[o*ADDR_W +: ADDR_W] : '0;
    acc    = e_mreq && mem_req_ack;
    e_ack  = acc ? (NUM_REQ'(1) << o) : '0;
    e_rdy  = (mem_ready && m_tags.size() > 0) ? (NUM_REQ'(1) << m_tags[0]) : '0;
    chk("model", 64'({mem_req, mem_addr, req_ack, ready, from_mem, err_orphan}),
                 64'({e_mreq, e_addr, e_ack, e_rdy, mem_data, m_orphan}));
    if (mem_ready) begin
      if (m_tags.size() > 0) void'(m_tags.pop_front());
      else m_orphan = 1'b1;
    end
    if (acc) m_tags.push_back(o);
    if (m_owner < 0) begin
      if (req != 0) m_owner = pick(req);
    end else if (acc) begin
      m_last  = m_owner;
      m_owner = (req != 0) ? pick(req) : -1;
    end else if (!req[o]) begin
      m_owner = -1;
    end
  endtask

  // Drive one cycle of inputs, check just before the following rising edge.
  task automatic step(input logic [NUM_REQ-1:0] r, input logic a, input logic rd);
    @(negedge clk);
    req = r; mem_req_ack = a; mem_ready = rd;
    mem_data = DATA_W'($urandom);
    if (rand_addr) req_addr = AW_ALL'({$urandom, $urandom});
    #1;
    model_cmp_update();
  endtask

  task automatic do_reset(input logic [NUM_REQ-1:0] r);
    @(negedge clk);
    rst = 1'b1; req = r; mem_req_ack = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic               ack, rdy;
    logic               e_mreq;
    logic [ADDR_W-1:0]  e_addr;
    logic [NUM_REQ-1:0] e_ack, e_rdy;
    logic               e_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Single requester, ack every cycle x4, response two cycles after each ack.
    tbl[0] = '{3'b001, 1'b0, 1'b0, 1'b0, 20'h00000, 3'b000, 3'b000, 1'b0};
    tbl[1] = '{3'b001, 1'b1, 1'b0, 1'b1, 20'h12000, 3'b001, 3'b000, 1'b0};
    tbl[2] = '{3'b001, 1'b1, 1'b0, 1'b1, 20'h12000, 3'b001, 3'b000, 1'b0};
    tbl[3] = '{3'b001, 1'b1, 1'b1, 1'b1, 20'h12000, 3'b001, 3'b001, 1'b0};
    tbl[4] = '{3'b001, 1'b1, 1'b1, 1'b1, 20'h12000, 3'b001, 3'b001, 1'b0};
    tbl[5] = '{3'b000, 1'b0, 1'b1, 1'b0, 20'h12000, 3'b000, 3'b001, 1'b0};
    tbl[6] = '{3'b000, 1'b0, 1'b1, 1'b0, 20'h00000, 3'b000, 3'b001, 1'b0};
    tbl[7] = '{3'b000, 1'b0, 1'b0, 1'b0, 20'h00000, 3'b000, 3'b000, 1'b0};

    rst = 1'b1; req = '0; mem_req_ack = 1'b0; mem_ready = 1'b0; mem_data = '0;
    req_addr = {20'h32000, 20'h21000, 20'h12000};
    model_reset();
    do_reset('0);

    // Reset state
    #1 chk("reset_outputs", 64'({mem_req, mem_addr, req_ack, ready, err_orphan}), 64'(0));

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].ack, tbl[i].rdy);
      chk($sformatf("tbl[%0d]", i),
          64'({mem_req, mem_addr, req_ack, ready, err_orphan}),
          64'({tbl[i].e_mreq, tbl[i].e_addr, tbl[i].e_ack, tbl[i].e_rdy, tbl[i].e_err}));
    end

    // Reset mid-burst drops outstanding tags; the late response is an orphan.
    do_reset('0);
    step(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b001, 1'b1, 1'b0);
    do_reset(3'b001);
    step(3'b001, 1'b0, 1'b1);
    chk("rst_mid_memreq", 64'(mem_req), 64'(0));
    chk("rst_mid_ready", 64'(ready), 64'(0));
    step(3'b000, 1'b0, 1'b0);
    chk("rst_mid_orphan", 64'(err_orphan), 64'(1));

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority contention.
    do_reset('0);
    step(3'b110, 1'b0, 1'b0);
    step(3'b110, 1'b1, 1'b0);  chk("fix_ack1", 64'(req_ack), 64'(3'b010));
    step(3'b111, 1'b1, 1'b1);  chk("fix_ack2", 64'(req_ack), 64'(3'b010));
    step(3'b111, 1'b1, 1'b1);  chk("fix_ack3", 64'(req_ack), 64'(3'b001));
    step(3'b111, 1'b1, 1'b1);  chk("fix_ack4", 64'(req_ack), 64'(3'b001));
    step(3'b100, 1'b1, 1'b1);  chk("fix_wd_ack", 64'(req_ack), 64'(3'b000));
    step(3'b100, 1'b0, 1'b0);  chk("fix_idle", 64'(mem_req), 64'(0));
    step(3'b100, 1'b1, 1'b0);  chk("fix_ack2only", 64'(req_ack), 64'(3'b100));
    step(3'b000, 1'b0, 1'b1);
`else
    // Round-robin rotation with everyone requesting.
    do_reset('0);
    step(3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 1'b1, i > 0);
      chk($sformatf("rr_ack%0d", i), 64'(req_ack), 64'(NUM_REQ'(1) << (i % 3)));
    end
    step(3'b000, 1'b0, 1'b1);
`endif

    // Tag FIFO full: acks while mem_req is low are ignored.
    do_reset('0);
    step(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < TAG_DEPTH; i++) step(3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(3'b001, 1'b1, 1'b0);
      chk("full_memreq", 64'({mem_req, req_ack}), 64'(0));
    end
    step(3'b001, 1'b1, 1'b1);
    chk("full_pop", 64'({mem_req, req_ack, ready}), 64'({1'b0, 3'b000, 3'b001}));
    step(3'b001, 1'b0, 1'b0);
    chk("full_reassert", 64'(mem_req), 64'(1));
    for (int i = 0; i < TAG_DEPTH - 1; i++) step(3'b000, 1'b0, 1'b1);

    // Orphan with empty FIFO, then withdrawal before ack.
    do_reset('0);
    step(3'b000, 1'b0, 1'b1);
    chk("orphan_noready", 64'(ready), 64'(0));
    step(3'b010, 1'b0, 1'b0);
    chk("orphan_sticky", 64'(err_orphan), 64'(1));
    step(3'b000, 1'b1, 1'b0);
    chk("wd_noack", 64'({mem_req, req_ack}), 64'(0));
    step(3'b000, 1'b0, 1'b0);
    chk("wd_idle_addr", 64'(mem_addr), 64'(0));
    step(3'b010, 1'b0, 1'b0);
    step(3'b010, 1'b0, 1'b0);
    chk("wd_regrant", 64'({mem_req, mem_addr}), 64'({1'b1, 20'h21000}));

    // Randomized traffic against the model.
    rand_addr = 1'b1;
    do_reset('0);
    begin
      logic [NUM_REQ-1:0] r;
      logic rd;
      r = '0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 399) == 0) do_reset(r);
        for (int b = 0; b < NUM_REQ; b++)
          if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
        if (m_tags.size() > 0) rd = ($urandom_range(0, 1) == 1);
        else                   rd = ($urandom_range(0, 255) == 0);
        step(r, $urandom_range(0, 1) == 1, rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
